// File: rtl/uart_rx.sv
// Oversampled UART receiver: 2-flop synchronizer, 3-sample majority vote per bit, one-cycle strobes.
// Optional parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    input  logic                 fifo_full,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SAMP_A    = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] SAMP_B    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] SAMP_C    = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic                  sync1_q, sync2_q;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [1:0]            samp_q, samp_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  dv_q, dv_d;
    logic                  fe_q, fe_d;
    logic                  bk_q, bk_d;
    logic                  ov_q, ov_d;
    logic                  par_bit_q;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit_d;
    logic                  par_bad_q, par_bad_d;
    logic                  pe_q, pe_d;
`endif

    logic rx_s;
    logic in_frame;
    logic vote;
    logic vote_tick;

    assign rx_s = sync2_q;

    always_comb begin
        in_frame = 1'b0;
        case (state_q)
            S_START, S_DATA, S_STOP: in_frame = 1'b1;
`ifdef UART_RX_PARITY_EN
            S_PARITY:                in_frame = 1'b1;
`endif
            default:                 in_frame = 1'b0;
        endcase
    end

    // Third sample is the live rx_s; the first two were captured on the preceding ticks.
    assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign vote_tick = baud_tick & in_frame & (tick_cnt_q == SAMP_C);

    // State register and all datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            samp_q     <= 2'b11;
            rx_data_q  <= '0;
            dv_q       <= 1'b0;
            fe_q       <= 1'b0;
            bk_q       <= 1'b0;
            ov_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            pe_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
            rx_data_q  <= rx_data_d;
            dv_q       <= dv_d;
            fe_q       <= fe_d;
            bk_q       <= bk_d;
            ov_q       <= ov_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= par_bit_d;
            par_bad_q  <= par_bad_d;
            pe_q       <= pe_d;
`endif
        end
    end

`ifndef UART_RX_PARITY_EN
    assign par_bit_q = 1'b0;
`endif

    // Next-state and counter logic
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
        par_bad_d  = par_bad_q;
`endif

        if (baud_tick && in_frame) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
            if (tick_cnt_q == SAMP_A) samp_d[0] = rx_s;
            if (tick_cnt_q == SAMP_B) samp_d[1] = rx_s;
        end

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (baud_tick && !rx_s) begin
                    // The detecting tick is tick 0 of the start bit, so the next one is tick 1.
                    state_d    = S_START;
                    tick_cnt_d = TW'(1);
                end
            end
            S_START: begin
                if (vote_tick) begin
                    bit_cnt_d = '0;
                    state_d   = vote ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (vote_tick) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (vote_tick) begin
                    par_bit_d = vote;
                    par_bad_d = vote ^ (^shift_q) ^ parity_odd;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (vote_tick) state_d = vote ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (baud_tick && rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: strobe next-values and the held byte
    always_comb begin
        rx_data_d = rx_data_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;
        bk_d      = 1'b0;
        ov_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_d      = 1'b0;
`endif
        busy      = (state_q != S_IDLE);

        if (state_q == S_STOP && vote_tick) begin
            if (vote) begin
                rx_data_d = shift_q;
                dv_d      = 1'b1;
                ov_d      = fifo_full;
`ifdef UART_RX_PARITY_EN
                pe_d      = par_bad_q;
`endif
            end else begin
                fe_d = 1'b1;
                bk_d = (shift_q == '0) && !par_bit_q;
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign data_valid  = dv_q;
    assign frame_err   = fe_q;
    assign break_det   = bk_q;
    assign overrun_err = ov_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level event model with scoreboard, plus literal spot checks.
module tb_uart_rx;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // 2 clk sync + (1+8+PB)*OS + OS/2 + 2 ticks + 1 clk, baud_tick every clk
  localparam int LAT_NOM = 2 + (1 + 8 + PB) * OS + OS / 2 + 2 + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic       fifo_full;
  logic       parity_odd;
  logic [7:0] rx_data;
  logic       data_valid, frame_err, break_det, overrun_err, busy;
  logic       parity_err_w;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .fifo_full  (fifo_full),
`ifdef UART_RX_PARITY_EN
    .parity_odd (parity_odd),
    .parity_err (parity_err_w),
`endif
    .rx_data    (rx_data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .break_det  (break_det),
    .overrun_err(overrun_err),
    .busy       (busy)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err_w = 1'b0;
`endif

  // clock / cycle counter
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_edge = 1'b0;
  always @(posedge clk) begin
    cyc++;
    rst_edge = rst;
  end

  // scoreboard: {dv, fe, bk, ov, pe, data}
  logic [12:0] exp_q[$];
  logic [7:0]  model_data = 8'h00;
  int n_vec = 0;
  int n_fail = 0;
  int dv_cnt = 0, bk_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int last_dv_cyc = 0;
  logic [7:0] last_dv_data = 8'h00;
  logic checking_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [12:0] e;
    logic [4:0]  got;
    if (checking_on) begin
      got = {data_valid, frame_err, break_det, overrun_err, parity_err_w};
      if (rst_edge) begin
        chk("reset_quiet", {27'd0, got}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        model_data = 8'h00;
      end else if (got != 5'b0) begin
        if (data_valid) begin
          dv_cnt++;
          last_dv_cyc  = cyc;
          last_dv_data = rx_data;
        end
        if (break_det)    bk_cnt++;
        if (overrun_err)  ov_cnt++;
        if (parity_err_w) pe_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {27'd0, got}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_flags", {27'd0, got}, {27'd0, e[12:8]});
          if (e[12]) model_data = e[7:0];
        end
      end
      chk("rx_data", {24'd0, rx_data}, {24'd0, model_data});
    end
  end

  // driver tasks
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ parity_odd;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len,
                            input logic ff, input logic par_v);
    logic pe_exp;
    logic brk;
`ifdef UART_RX_PARITY_EN
    pe_exp = (par_v != good_par(d));
    brk    = (d == 8'h00) && !par_v;
`else
    pe_exp = 1'b0;
    brk    = (d == 8'h00);
`endif
    if (stop_v) exp_q.push_back({1'b1, 1'b0, 1'b0, ff, pe_exp, d});
    else        exp_q.push_back({1'b0, 1'b1, brk, 1'b0, 1'b0, d});
    drive(1'b0, OS);
    fifo_full = ff;
    for (int i = 0; i < 8; i++) drive(d[i], OS);
`ifdef UART_RX_PARITY_EN
    drive(par_v, OS);
`endif
    drive(stop_v, stop_len);
    fifo_full = 1'b0;
    rx = 1'b1;
  endtask

  // frame interrupted by rst in the middle of data bit 4; rst held until the frame ends
  task automatic send_frame_reset(input logic [7:0] d);
    drive(1'b0, OS);
    for (int i = 0; i < 4; i++) drive(d[i], OS);
    drive(d[4], OS / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_strobes_busy", {27'd0, data_valid, frame_err, break_det, overrun_err, busy}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    @(negedge clk);
    drive(d[4], OS / 2 - 1);
    for (int i = 5; i < 8; i++) drive(d[i], OS);
`ifdef UART_RX_PARITY_EN
    drive(good_par(d), OS);
`endif
    drive(1'b1, OS);
    rst = 1'b0;
  endtask

  // main stimulus
  initial begin
    int c0, dv0, bk0, ov0, pe0, lat, waited;
    rst        = 1'b1;
    baud_tick  = 1'b1;
    rx         = 1'b1;
    fifo_full  = 1'b0;
    parity_odd = 1'b0;
    @(posedge clk);
    checking_on = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset_idle", {30'd0, busy, data_valid}, 32'd0);
    drive(1'b1, 10);

    // 1: plain frame 0xA5
    c0 = cyc; dv0 = dv_cnt;
    send_frame(8'hA5, 1'b1, OS, 1'b0, good_par(8'hA5));
    drive(1'b1, 20);
    chk("a5_count", dv_cnt - dv0, 32'd1);
    chk("a5_data", {24'd0, last_dv_data}, 32'hA5);
    lat = last_dv_cyc - c0;
    chk("a5_latency_window", {31'd0, (lat >= LAT_NOM - 3) && (lat <= LAT_NOM)}, 32'd1);

    // 2: 4-tick glitch
    drive(1'b0, 4);
    chk("glitch_busy_rise", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    waited = 0;
    while (busy && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("glitch_busy_fall", {31'd0, busy}, 32'd0);
    drive(1'b1, 20);

    // 3: framing error then a good frame
    send_frame(8'h3C, 1'b0, OS, 1'b0, good_par(8'h3C));
    drive(1'b1, 20);
    chk("ferr_hold", {24'd0, rx_data}, 32'hA5);
    send_frame(8'h5A, 1'b1, OS, 1'b0, good_par(8'h5A));
    drive(1'b1, 20);
    chk("after_ferr_data", {24'd0, rx_data}, 32'h5A);

    // 4: break, 12 bit times low
    bk0 = bk_cnt;
    exp_q.push_back({5'b01100, 8'h00});
    drive(1'b0, 12 * OS);
    drive(1'b1, 40);
    chk("break_count", bk_cnt - bk0, 32'd1);
    send_frame(8'h81, 1'b1, OS, 1'b0, good_par(8'h81));
    drive(1'b1, 20);
    chk("after_break_data", {24'd0, rx_data}, 32'h81);

    // 5: back-to-back, second start at 9/16 of first stop, overrun on the second
    ov0 = ov_cnt; dv0 = dv_cnt;
    send_frame(8'h00, 1'b1, 9, 1'b0, good_par(8'h00));
    send_frame(8'hFF, 1'b1, OS, 1'b1, good_par(8'hFF));
    drive(1'b1, 20);
    chk("b2b_count", dv_cnt - dv0, 32'd2);
    chk("b2b_overrun_count", ov_cnt - ov0, 32'd1);
    chk("b2b_data", {24'd0, rx_data}, 32'hFF);

    // 6: reset mid-frame, then recovery
    dv0 = dv_cnt;
    send_frame_reset(8'h77);
    drive(1'b1, 20);
    chk("rst_no_strobe", dv_cnt - dv0, 32'd0);
    send_frame(8'h12, 1'b1, OS, 1'b0, good_par(8'h12));
    drive(1'b1, 20);
    chk("after_rst_data", {24'd0, rx_data}, 32'h12);
`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt;
    send_frame(8'h12, 1'b1, OS, 1'b0, 1'b1);
    drive(1'b1, 20);
    chk("parity_err_count", pe_cnt - pe0, 32'd1);
    chk("parity_err_data", {24'd0, rx_data}, 32'h12);
`else
    pe0 = pe_cnt;
    chk("no_parity_strobes", pe_cnt - pe0, 32'd0);
`endif

    chk("pending_events", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
